// File: rtl/proc_core_param.sv
// Parametrised multi-cycle processor core: instruction register, step counter, register file,
// A/G ALU registers and shared bus. Define PROC_CORE_FLAGS_EN to register ZF/CF on ALU ops.
module proc_core_param #(
    parameter  int W    = 10,
    parameter  int NREG = 4,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          CLKb,
    input  logic          RST,
    input  logic [W-1:0]  D,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [AW-1:0] PEEK_ADDR,
    output logic [W-1:0]  PEEK_DATA,
    output logic [W-1:0]  BUS,
    output logic [1:0]    STEP,
    output logic          DONE,
    output logic          ZF,
    output logic          CF
);
    localparam int IRW = 4 + 2 * AW;

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;

    step_e          step_q, step_d;
    logic [IRW-1:0] ir_q, ir_d;
    logic [W-1:0]   regs_q [NREG];
    logic [W-1:0]   regs_d [NREG];
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   g_q, g_d;
    logic           done_q, done_d;
    logic [3:0]     op_s;
    logic [AW-1:0]  rx_s, ry_s;
    logic           is_alu_s;
    logic [W-1:0]   bus_s;
    logic           in_ready_s;
`ifdef PROC_CORE_FLAGS_EN
    logic           zf_q, zf_d;
    logic           cf_q, cf_d;
`endif

    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef PROC_CORE_FLAGS_EN
    // A wrapped sum is smaller than either addend exactly when the add carried out.
    function automatic logic carry_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        logic         c;
        s = a + b;
        case (op)
            OP_ADD:  c = (s < a);
            OP_SUB:  c = (a < b);
            default: c = 1'b0;
        endcase
        return c;
    endfunction
`endif

    // Only the opcode and register fields of the instruction are kept.
    assign op_s     = ir_q[IRW-1 -: 4];
    assign rx_s     = ir_q[2*AW-1:AW];
    assign ry_s     = ir_q[AW-1:0];
    assign is_alu_s = (op_s >= OP_ADD) && (op_s <= OP_NOT);

    // Step sequencing, bus source selection and register/ALU next-state.
    always_comb begin
        step_d     = step_q;
        ir_d       = ir_q;
        regs_d     = regs_q;
        a_d        = a_q;
        g_d        = g_q;
        done_d     = 1'b0;
        bus_s      = '0;
        in_ready_s = 1'b0;
`ifdef PROC_CORE_FLAGS_EN
        zf_d       = zf_q;
        cf_d       = cf_q;
`endif
        case (step_q)
            T0: begin
                in_ready_s = 1'b1;
                if (IN_VALID) begin
                    bus_s  = D;
                    ir_d   = {D[W-1 -: 4], D[2*AW-1:AW], D[AW-1:0]};
                    step_d = T1;
                end else begin
                    step_d = T0;
                end
            end
            T1: begin
                if (op_s == OP_LOAD) begin
                    in_ready_s = 1'b1;
                    if (IN_VALID) begin
                        bus_s        = D;
                        regs_d[rx_s] = D;
                        step_d       = T0;
                        done_d       = 1'b1;
                    end else begin
                        step_d = T1;
                    end
                end else if (op_s == OP_MOV) begin
                    bus_s        = regs_q[ry_s];
                    regs_d[rx_s] = regs_q[ry_s];
                    step_d       = T0;
                    done_d       = 1'b1;
                end else if (is_alu_s) begin
                    bus_s  = regs_q[rx_s];
                    a_d    = regs_q[rx_s];
                    step_d = T2;
                end else begin
                    step_d = T0;
                    done_d = 1'b1;
                end
            end
            T2: begin
                bus_s  = (op_s == OP_NOT) ? '0 : regs_q[ry_s];
                g_d    = alu_f(op_s, a_q, bus_s);
                step_d = T3;
`ifdef PROC_CORE_FLAGS_EN
                zf_d   = (alu_f(op_s, a_q, bus_s) == '0);
                cf_d   = carry_f(op_s, a_q, bus_s);
`endif
            end
            T3: begin
                bus_s        = g_q;
                regs_d[rx_s] = g_q;
                step_d       = T0;
                done_d       = 1'b1;
            end
            default: begin
                step_d = T0;
            end
        endcase
    end

    // State registers; reset aborts any instruction in flight.
    always_ff @(posedge CLKb) begin
        if (RST) begin
            step_q <= T0;
            ir_q   <= '0;
            a_q    <= '0;
            g_q    <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
`ifdef PROC_CORE_FLAGS_EN
            zf_q   <= 1'b0;
            cf_q   <= 1'b0;
`endif
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
            a_q    <= a_d;
            g_q    <= g_d;
            done_q <= done_d;
            regs_q <= regs_d;
`ifdef PROC_CORE_FLAGS_EN
            zf_q   <= zf_d;
            cf_q   <= cf_d;
`endif
        end
    end

    assign IN_READY  = in_ready_s;
    assign BUS       = bus_s;
    assign STEP      = step_q;
    assign DONE      = done_q;
    assign PEEK_DATA = regs_q[PEEK_ADDR];
`ifdef PROC_CORE_FLAGS_EN
    assign ZF        = zf_q;
    assign CF        = cf_q;
`else
    assign ZF        = 1'b0;
    assign CF        = 1'b0;
`endif

endmodule

// File: tb/tb_proc_core_param.sv
// Table-driven bench for proc_core_param (W=10, NREG=4) with an in-order completion scoreboard.
module tb_proc_core_param;
    localparam int W    = 10;
    localparam int NREG = 4;
    localparam int AW   = 2;
`ifdef PROC_CORE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic          CLKb, RST, IN_VALID, IN_READY, DONE, ZF, CF;
    logic [W-1:0]  D, PEEK_DATA, BUS;
    logic [AW-1:0] PEEK_ADDR;
    logic [1:0]    STEP;

    typedef struct {
        logic [9:0] instr;
        logic [9:0] imm;
        int         stall;
        logic [1:0] rd;
        logic [9:0] val;
        int         lat;
        bit         alu;
        logic [9:0] b0, b1, b2;
        bit         zf, cf;
    } vec_t;

    typedef struct {
        logic [1:0] rd;
        logic [9:0] val;
        int         lat;
        bit         zf, cf;
        int         idx;
    } exp_t;

    vec_t vecs [21];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    proc_core_param #(.W(W), .NREG(NREG)) dut (
        .CLKb(CLKb), .RST(RST), .D(D), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .PEEK_ADDR(PEEK_ADDR), .PEEK_DATA(PEEK_DATA), .BUS(BUS), .STEP(STEP),
        .DONE(DONE), .ZF(ZF), .CF(CF)
    );

    initial CLKb = 1'b0;
    always #5 CLKb = ~CLKb;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] instr, input logic [9:0] imm, input int stall,
                                input logic [1:0] rd, input logic [9:0] val, input int lat, input bit alu,
                                input logic [9:0] b0, input logic [9:0] b1, input logic [9:0] b2,
                                input bit zf, input bit cf);
        vec_t v;
        v.instr = instr; v.imm = imm; v.stall = stall; v.rd = rd; v.val = val; v.lat = lat;
        v.alu = alu; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.zf = zf; v.cf = cf;
        return v;
    endfunction

    // Called at a negedge; returns within the same low phase.
    task automatic check_reset(input string tag);
        chk({tag, "_step"}, 32'(STEP), 32'd0);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
        chk({tag, "_ready"}, 32'(IN_READY), 32'd1);
        chk({tag, "_bus"}, 32'(BUS), 32'd0);
        chk({tag, "_zf"}, 32'(ZF), 32'd0);
        chk({tag, "_cf"}, 32'(CF), 32'd0);
        for (int i = 0; i < NREG; i++) begin
            PEEK_ADDR = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 32'(PEEK_DATA), 32'd0);
        end
    endtask

    // Issue one instruction at a negedge in T0; returns at the negedge where DONE is seen.
    task automatic issue(input vec_t v, input int idx);
        exp_t e;
        bit   done;
        chk($sformatf("r%0d_t0_step", idx), 32'(STEP), 32'd0);
        chk($sformatf("r%0d_t0_ready", idx), 32'(IN_READY), 32'd1);
        D = v.instr;
        IN_VALID = 1'b1;
        PEEK_ADDR = v.rd;
        #1;
        chk($sformatf("r%0d_t0_bus", idx), 32'(BUS), 32'(v.instr));
        e.rd = v.rd; e.val = v.val; e.lat = v.lat; e.zf = v.zf; e.cf = v.cf; e.idx = idx;
        sb.push_back(e);
        @(posedge CLKb);
        done = 1'b0;
        for (int k = 1; k <= 16 && !done; k++) begin
            @(negedge CLKb);
            if (DONE) begin
                done = 1'b1;
                e = sb.pop_front();
                chk($sformatf("r%0d_lat", e.idx), 32'(k), 32'(e.lat));
                chk($sformatf("r%0d_reg", e.idx), 32'(PEEK_DATA), 32'(e.val));
                chk($sformatf("r%0d_zf", e.idx), 32'(ZF), FLAGS ? 32'(e.zf) : 32'd0);
                chk($sformatf("r%0d_cf", e.idx), 32'(CF), FLAGS ? 32'(e.cf) : 32'd0);
                chk($sformatf("r%0d_done_step", e.idx), 32'(STEP), 32'd0);
                IN_VALID = 1'b0;
            end else if (v.instr[9:6] == 4'd0) begin
                if (k <= v.stall) begin
                    IN_VALID = 1'b0;
                    #1;
                    chk($sformatf("r%0d_stall_step", idx), 32'(STEP), 32'd1);
                    chk($sformatf("r%0d_stall_ready", idx), 32'(IN_READY), 32'd1);
                    chk($sformatf("r%0d_stall_bus", idx), 32'(BUS), 32'd0);
                end else begin
                    D = v.imm;
                    IN_VALID = 1'b1;
                    #1;
                    chk($sformatf("r%0d_imm_ready", idx), 32'(IN_READY), 32'd1);
                    chk($sformatf("r%0d_imm_bus", idx), 32'(BUS), 32'(v.imm));
                end
            end else begin
                IN_VALID = 1'b0;
                if (k == 1) chk($sformatf("r%0d_t1_ready", idx), 32'(IN_READY), 32'd0);
                if (v.alu && k <= 3) begin
                    chk($sformatf("r%0d_step%0d", idx, k), 32'(STEP), 32'(k));
                    chk($sformatf("r%0d_bus%0d", idx, k), 32'(BUS),
                        32'((k == 1) ? v.b0 : ((k == 2) ? v.b1 : v.b2)));
                    if (k == 3) chk($sformatf("r%0d_peek_old", idx), 32'(PEEK_DATA), 32'(v.b0));
                end
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL r%0d_timeout: no DONE within 16 cycles, required one", idx);
            sb.delete();
            IN_VALID = 1'b0;
        end
    endtask

    initial begin
        //           instr    imm     st rd  val     lat alu b0      b1      b2      zf cf
        vecs[0]  = mk(10'h004, 10'h005, 0, 1, 10'h005, 2, 0, 10'h000, 10'h000, 10'h000, 0, 0);
        vecs[1]  = mk(10'h008, 10'h007, 0, 2, 10'h007, 2, 0, 10'h000, 10'h000, 10'h000, 0, 0);
        vecs[2]  = mk(10'h086, 10'h000, 0, 1, 10'h00C, 4, 1, 10'h005, 10'h007, 10'h00C, 0, 0);
        vecs[3]  = mk(10'h004, 10'h003, 0, 1, 10'h003, 2, 0, 10'h000, 10'h000, 10'h000, 0, 0);
        vecs[4]  = mk(10'h008, 10'h005, 0, 2, 10'h005, 2, 0, 10'h000, 10'h000, 10'h000, 0, 0);
        vecs[5]  = mk(10'h0C6, 10'h000, 0, 1, 10'h3FE, 4, 1, 10'h003, 10'h005, 10'h3FE, 0, 1);
        vecs[6]  = mk(10'h00C, 10'h3FF, 3, 3, 10'h3FF, 5, 0, 10'h000, 10'h000, 10'h000, 0, 1);
        vecs[7]  = mk(10'h1C0, 10'h000, 0, 0, 10'h3FF, 4, 1, 10'h000, 10'h000, 10'h3FF, 0, 0);
        vecs[8]  = mk(10'h200, 10'h000, 0, 0, 10'h3FF, 2, 0, 10'h000, 10'h000, 10'h000, 0, 0);
        vecs[9]  = mk(10'h08F, 10'h000, 0, 3, 10'h3FE, 4, 1, 10'h3FF, 10'h3FF, 10'h3FE, 0, 1);
        vecs[10] = mk(10'h0CA, 10'h000, 0, 2, 10'h000, 4, 1, 10'h005, 10'h005, 10'h000, 1, 0);
        vecs[11] = mk(10'h041, 10'h000, 0, 0, 10'h3FE, 2, 0, 10'h000, 10'h000, 10'h000, 1, 0);
        vecs[12] = mk(10'h008, 10'h155, 0, 2, 10'h155, 2, 0, 10'h000, 10'h000, 10'h000, 1, 0);
        vecs[13] = mk(10'h10E, 10'h000, 0, 3, 10'h154, 4, 1, 10'h3FE, 10'h155, 10'h154, 0, 0);
        vecs[14] = mk(10'h148, 10'h000, 0, 2, 10'h3FF, 4, 1, 10'h155, 10'h3FE, 10'h3FF, 0, 0);
        vecs[15] = mk(10'h18A, 10'h000, 0, 2, 10'h000, 4, 1, 10'h3FF, 10'h3FF, 10'h000, 1, 0);
        vecs[16] = mk(10'h3C5, 10'h000, 0, 1, 10'h3FE, 2, 0, 10'h000, 10'h000, 10'h000, 1, 0);
        vecs[17] = mk(10'h004, 10'h001, 0, 1, 10'h001, 2, 0, 10'h000, 10'h000, 10'h000, 1, 0);
        vecs[18] = mk(10'h00C, 10'h3FF, 0, 3, 10'h3FF, 2, 0, 10'h000, 10'h000, 10'h000, 1, 0);
        vecs[19] = mk(10'h08D, 10'h000, 0, 3, 10'h000, 4, 1, 10'h3FF, 10'h001, 10'h000, 1, 1);
        vecs[20] = mk(10'h008, 10'h2AA, 0, 2, 10'h2AA, 2, 0, 10'h000, 10'h000, 10'h000, 0, 0);

        RST = 1'b1;
        D = '0;
        IN_VALID = 1'b0;
        PEEK_ADDR = '0;
        repeat (2) @(posedge CLKb);
        @(negedge CLKb);
        RST = 1'b0;
        check_reset("rst0");
        @(negedge CLKb);

        // Back-to-back: each issue after the first starts in the previous DONE cycle.
        for (int i = 0; i < 20; i++) begin
            issue(vecs[i], i);
        end
        @(negedge CLKb);
        chk("done_pulse_width", 32'(DONE), 32'd0);

        // Reset held for two cycles while an ADD sits in T2.
        D = 10'h085;
        IN_VALID = 1'b1;
        PEEK_ADDR = 2'd1;
        @(posedge CLKb);
        @(negedge CLKb);
        IN_VALID = 1'b0;
        chk("rst_mid_t1", 32'(STEP), 32'd1);
        @(negedge CLKb);
        chk("rst_mid_t2", 32'(STEP), 32'd2);
        RST = 1'b1;
        repeat (2) @(negedge CLKb);
        RST = 1'b0;
        check_reset("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLKb);
            chk($sformatf("rst_mid_nodone%0d", i), 32'(DONE), 32'd0);
            chk($sformatf("rst_mid_idle%0d", i), 32'(STEP), 32'd0);
        end

        issue(vecs[20], 20);
        @(negedge CLKb);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
